// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction fetch (pre-IF + IF) for the 5-stage LoongArch pipe.
//
// Generates nextpc, drives the 1-cycle-latency synchronous inst SRAM, holds
// a returned word in a one-entry buffer while ID stalls, and applies branch
// redirects from ID (squashing the wrong-path slot in IF).
//
// Ports
//   clk              in   clock, rising edge
//   resetn           in   asynchronous active-low reset
//   id_allowin       in   ID can accept an instruction this cycle
//   br_taken         in   one-cycle redirect pulse from ID
//   br_target        in   redirect address (valid with br_taken)
//   if_to_id_valid   out  pc/inst carry a valid instruction
//   if_to_id_pc      out  PC of the presented instruction
//   if_to_id_inst    out  presented instruction word
//   inst_sram_en     out  fetch request
//   inst_sram_we     out  byte write enables, always 0
//   inst_sram_addr   out  fetch address (= nextpc)
//   inst_sram_wdata  out  write data, always 0
//   inst_sram_rdata  in   read data, valid the cycle after a request
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_to_id_valid,
  output logic [31:0] if_to_id_pc,
  output logic [31:0] if_to_id_inst,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        r_to_fs_valid;
  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic        r_buf_valid;
  logic [31:0] r_inst_buf;
  logic        r_br_pend;
  logic [31:0] r_br_pend_target;
  logic        r_req_d;          // a request was issued last cycle -> rdata valid now

  logic        w_fs_ready_go;
  logic        w_fs_allowin;
  logic        w_req;
  logic        w_fire;
  logic [31:0] w_seq_pc;
  logic [31:0] w_nextpc;

  assign w_fs_ready_go = 1'b1;
  assign w_fs_allowin  = !r_fs_valid || (w_fs_ready_go && id_allowin);

  // The instruction in IF while ID redirects is on the wrong path.
  assign if_to_id_valid = r_fs_valid && !br_taken;
  assign w_fire         = if_to_id_valid && id_allowin;

  assign w_seq_pc = r_fs_pc + 32'd4;
  assign w_nextpc = br_taken  ? br_target :
                    r_br_pend ? r_br_pend_target :
                                w_seq_pc;

  assign w_req           = r_to_fs_valid && w_fs_allowin;
  assign inst_sram_en    = w_req;
  assign inst_sram_addr  = w_nextpc;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign if_to_id_pc   = r_fs_pc;
  assign if_to_id_inst = r_buf_valid ? r_inst_buf : inst_sram_rdata;

  // pre-IF / IF control state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_to_fs_valid <= 1'b0;
      r_fs_valid    <= 1'b0;
      r_fs_pc       <= RESET_PC - 32'd4;
      r_br_pend     <= 1'b0;
      r_req_d       <= 1'b0;
    end else begin
      r_to_fs_valid <= 1'b1;
      r_req_d       <= w_req;

      if (w_req) begin
        r_fs_valid <= 1'b1;
        r_fs_pc    <= w_nextpc;
      end else if (br_taken) begin
        // IF could not accept the redirect: squash now, fetch target later.
        r_fs_valid <= 1'b0;
      end else if (w_fire) begin
        r_fs_valid <= 1'b0;
      end

      if (w_req) begin
        r_br_pend <= 1'b0;
      end else if (br_taken) begin
        r_br_pend <= 1'b1;
      end
    end
  end

  // Pending redirect target (data only, qualified by r_br_pend)
  always_ff @(posedge clk) begin
    if (br_taken && !w_req) begin
      r_br_pend_target <= br_target;
    end
  end

  // Instruction buffer control
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_buf_valid <= 1'b0;
    end else if (br_taken || w_fire) begin
      r_buf_valid <= 1'b0;
    end else if (r_req_d && r_fs_valid && !id_allowin) begin
      r_buf_valid <= 1'b1;
    end
  end

  // Instruction buffer data: capture rdata in its only valid cycle when ID stalls
  always_ff @(posedge clk) begin
    if (!br_taken && r_req_d && r_fs_valid && !id_allowin && !r_buf_valid) begin
      r_inst_buf <= inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        resetn;
  logic        id_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_to_id_valid;
  logic [31:0] if_to_id_pc;
  logic [31:0] if_to_id_inst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int n_checks;
  int n_errors;

  if_stage #(.RESET_PC(32'h1c000000)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .id_allowin      (id_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .if_to_id_valid  (if_to_id_valid),
    .if_to_id_pc     (if_to_id_pc),
    .if_to_id_inst   (if_to_id_inst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents seen by the bench
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c000008) return 32'h02800421;
    return a ^ 32'h5a5a0000;
  endfunction

  // SRAM model: 1-cycle latency, garbage when no request was made
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
    else              inst_sram_rdata <= 32'hdeadbeef;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; id_allowin = 1'b1; br_taken = 1'b0; br_target = 32'h0;
    step(); step();
    n_checks++; if (if_to_id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", if_to_id_valid); end
    n_checks++; if (inst_sram_en !== 1'b0) begin n_errors++; $display("FAIL reset_en: got %b want 0", inst_sram_en); end
    n_checks++; if (inst_sram_we !== 4'h0) begin n_errors++; $display("FAIL sram_we: got %h want 0", inst_sram_we); end
    n_checks++; if (inst_sram_wdata !== 32'h0) begin n_errors++; $display("FAIL sram_wdata: got %h want 0", inst_sram_wdata); end
  endtask

  task automatic test_startup();
    resetn = 1'b1;
    #1;
    n_checks++; if (inst_sram_en !== 1'b0) begin n_errors++; $display("FAIL start_en0: got %b want 0", inst_sram_en); end
    step();
    n_checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000000) begin n_errors++; $display("FAIL start_req0: got en=%b addr=%h want en=1 addr=1c000000", inst_sram_en, inst_sram_addr); end
    n_checks++; if (if_to_id_valid !== 1'b0) begin n_errors++; $display("FAIL start_valid0: got %b want 0", if_to_id_valid); end
    step();
    n_checks++; if (if_to_id_valid !== 1'b1 || if_to_id_pc !== 32'h1c000000 || if_to_id_inst !== mem_word(32'h1c000000)) begin n_errors++; $display("FAIL start_id0: got v=%b pc=%h inst=%h want v=1 pc=1c000000 inst=%h", if_to_id_valid, if_to_id_pc, if_to_id_inst, mem_word(32'h1c000000)); end
    n_checks++; if (inst_sram_addr !== 32'h1c000004) begin n_errors++; $display("FAIL start_addr1: got %h want 1c000004", inst_sram_addr); end
    step();
    n_checks++; if (if_to_id_pc !== 32'h1c000004 || inst_sram_addr !== 32'h1c000008) begin n_errors++; $display("FAIL start_seq2: got pc=%h addr=%h want pc=1c000004 addr=1c000008", if_to_id_pc, inst_sram_addr); end
    step();
    n_checks++; if (if_to_id_pc !== 32'h1c000008 || if_to_id_inst !== 32'h02800421 || inst_sram_addr !== 32'h1c00000c) begin n_errors++; $display("FAIL start_seq3: got pc=%h inst=%h addr=%h want 1c000008 02800421 1c00000c", if_to_id_pc, if_to_id_inst, inst_sram_addr); end
  endtask

  task automatic test_stall();
    id_allowin = 1'b0;
    #1;
    n_checks++; if (inst_sram_en !== 1'b0 || if_to_id_valid !== 1'b1 || if_to_id_inst !== 32'h02800421) begin n_errors++; $display("FAIL stall_c0: got en=%b v=%b inst=%h want en=0 v=1 inst=02800421", inst_sram_en, if_to_id_valid, if_to_id_inst); end
    for (int i = 1; i < 3; i++) begin
      step();
      n_checks++; if (inst_sram_en !== 1'b0 || if_to_id_pc !== 32'h1c000008 || if_to_id_inst !== 32'h02800421) begin n_errors++; $display("FAIL stall_c%0d: got en=%b pc=%h inst=%h want en=0 pc=1c000008 inst=02800421", i, inst_sram_en, if_to_id_pc, if_to_id_inst); end
    end
    step();
    id_allowin = 1'b1;
    #1;
    n_checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00000c || if_to_id_pc !== 32'h1c000008 || if_to_id_inst !== 32'h02800421) begin n_errors++; $display("FAIL stall_release: got en=%b addr=%h pc=%h inst=%h want 1 1c00000c 1c000008 02800421", inst_sram_en, inst_sram_addr, if_to_id_pc, if_to_id_inst); end
    step();
    n_checks++; if (if_to_id_valid !== 1'b1 || if_to_id_pc !== 32'h1c00000c || if_to_id_inst !== mem_word(32'h1c00000c) || inst_sram_addr !== 32'h1c000010) begin n_errors++; $display("FAIL stall_after: got v=%b pc=%h inst=%h addr=%h want 1 1c00000c %h 1c000010", if_to_id_valid, if_to_id_pc, if_to_id_inst, inst_sram_addr, mem_word(32'h1c00000c)); end
  endtask

  task automatic test_redirect();
    step();
    n_checks++; if (if_to_id_valid !== 1'b1 || if_to_id_pc !== 32'h1c000010) begin n_errors++; $display("FAIL redir_pre: got v=%b pc=%h want 1 1c000010", if_to_id_valid, if_to_id_pc); end
    br_taken = 1'b1; br_target = 32'h1c000100;
    #1;
    n_checks++; if (if_to_id_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin n_errors++; $display("FAIL redir_squash: got v=%b en=%b addr=%h want 0 1 1c000100", if_to_id_valid, inst_sram_en, inst_sram_addr); end
    step();
    br_taken = 1'b0;
    #1;
    n_checks++; if (if_to_id_valid !== 1'b1 || if_to_id_pc !== 32'h1c000100 || if_to_id_inst !== mem_word(32'h1c000100) || inst_sram_addr !== 32'h1c000104) begin n_errors++; $display("FAIL redir_target: got v=%b pc=%h inst=%h addr=%h want 1 1c000100 %h 1c000104", if_to_id_valid, if_to_id_pc, if_to_id_inst, inst_sram_addr, mem_word(32'h1c000100)); end
  endtask

  task automatic test_redirect_buffered();
    id_allowin = 1'b0;
    step();
    n_checks++; if (if_to_id_valid !== 1'b1 || if_to_id_inst !== mem_word(32'h1c000100) || inst_sram_en !== 1'b0) begin n_errors++; $display("FAIL bufredir_hold: got v=%b inst=%h en=%b want 1 %h 0", if_to_id_valid, if_to_id_inst, inst_sram_en, mem_word(32'h1c000100)); end
    br_taken = 1'b1; br_target = 32'h1c000200;
    #1;
    n_checks++; if (if_to_id_valid !== 1'b0 || inst_sram_en !== 1'b0) begin n_errors++; $display("FAIL bufredir_squash: got v=%b en=%b want 0 0", if_to_id_valid, inst_sram_en); end
    step();
    br_taken = 1'b0;
    #1;
    n_checks++; if (if_to_id_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000200) begin n_errors++; $display("FAIL bufredir_pend: got v=%b en=%b addr=%h want 0 1 1c000200", if_to_id_valid, inst_sram_en, inst_sram_addr); end
    step();
    n_checks++; if (if_to_id_valid !== 1'b1 || if_to_id_pc !== 32'h1c000200) begin n_errors++; $display("FAIL bufredir_pc: got v=%b pc=%h want 1 1c000200", if_to_id_valid, if_to_id_pc); end
    step();
    id_allowin = 1'b1;
    #1;
    n_checks++; if (if_to_id_valid !== 1'b1 || if_to_id_pc !== 32'h1c000200 || if_to_id_inst !== mem_word(32'h1c000200) || inst_sram_addr !== 32'h1c000204) begin n_errors++; $display("FAIL bufredir_first: got v=%b pc=%h inst=%h addr=%h want 1 1c000200 %h 1c000204", if_to_id_valid, if_to_id_pc, if_to_id_inst, inst_sram_addr, mem_word(32'h1c000200)); end
    step();
    n_checks++; if (if_to_id_pc !== 32'h1c000204 || if_to_id_valid !== 1'b1) begin n_errors++; $display("FAIL bufredir_next: got v=%b pc=%h want 1 1c000204", if_to_id_valid, if_to_id_pc); end
  endtask

  task automatic test_async_reset();
    br_taken = 1'b1; br_target = 32'h1c000040;
    step();
    br_taken = 1'b0;
    #1;
    n_checks++; if (if_to_id_valid !== 1'b1 || if_to_id_pc !== 32'h1c000040 || inst_sram_en !== 1'b1) begin n_errors++; $display("FAIL areset_pre: got v=%b pc=%h en=%b want 1 1c000040 1", if_to_id_valid, if_to_id_pc, inst_sram_en); end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (if_to_id_valid !== 1'b0 || inst_sram_en !== 1'b0) begin n_errors++; $display("FAIL areset_drop: got v=%b en=%b want 0 0", if_to_id_valid, inst_sram_en); end
    step();
    resetn = 1'b1;
    #1;
    n_checks++; if (inst_sram_en !== 1'b0) begin n_errors++; $display("FAIL areset_en0: got %b want 0", inst_sram_en); end
    step();
    n_checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000000 || if_to_id_valid !== 1'b0) begin n_errors++; $display("FAIL areset_restart: got en=%b addr=%h v=%b want 1 1c000000 0", inst_sram_en, inst_sram_addr, if_to_id_valid); end
    step();
    n_checks++; if (if_to_id_valid !== 1'b1 || if_to_id_pc !== 32'h1c000000 || if_to_id_inst !== mem_word(32'h1c000000)) begin n_errors++; $display("FAIL areset_first: got v=%b pc=%h inst=%h want 1 1c000000 %h", if_to_id_valid, if_to_id_pc, if_to_id_inst, mem_word(32'h1c000000)); end
  endtask

  task automatic test_wrap();
    br_taken = 1'b1; br_target = 32'hfffffffc;
    step();
    br_taken = 1'b0;
    #1;
    n_checks++; if (if_to_id_pc !== 32'hfffffffc || if_to_id_valid !== 1'b1 || inst_sram_addr !== 32'h00000000) begin n_errors++; $display("FAIL wrap_addr: got pc=%h v=%b addr=%h want fffffffc 1 00000000", if_to_id_pc, if_to_id_valid, inst_sram_addr); end
    step();
    n_checks++; if (if_to_id_pc !== 32'h00000000 || if_to_id_inst !== 32'h5a5a0000) begin n_errors++; $display("FAIL wrap_pc: got pc=%h inst=%h want 00000000 5a5a0000", if_to_id_pc, if_to_id_inst); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_buffered();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage (pre-IF plus IF) that feeds the ID stage of the 5-stage LoongArch pipeline.
- Generates the next PC and drives the synchronous inst SRAM, which has a 1-cycle read latency.
- Holds the returned instruction in a one-entry buffer while ID stalls, so no fetched word is lost or re-fetched.
- Applies branch redirects from ID, squashes the wrong-path instruction, and presents pc/inst to ID with a valid/allowin handshake.

Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- id_allowin  input  1  ID stage can accept an instruction this cycle.
- br_taken  input  1  redirect from ID; a one-cycle pulse, already qualified by ID valid/ready_go.
- br_target  input  32  redirect address, valid when br_taken=1.
- if_to_id_valid  output  1  pc/inst outputs carry a valid instruction.
- if_to_id_pc  output  32  PC of the presented instruction.
- if_to_id_inst  output  32  presented instruction word.
- inst_sram_en  output  1  fetch request.
- inst_sram_we  output  4  constant 0.
- inst_sram_addr  output  32  fetch address (equals nextpc).
- inst_sram_wdata  output  32  constant 0.
- inst_sram_rdata  input  32  read data; valid the cycle after an accepted request.

Behaviour:
Reset values (async, resetn=0):
- fs_pc=RESET_PC-4.
- to_fs_valid=0, fs_valid=0, buf_valid=0, br_pend=0.
- Outputs: if_to_id_valid=0, inst_sram_en=0.

Start-up:
- to_fs_valid becomes 1 on the first rising edge with resetn=1 and stays 1.
- The first request therefore has addr=RESET_PC, issued one cycle after reset release.

Handshake:
- fs_ready_go=1.
- fs_allowin = !fs_valid | (fs_ready_go & id_allowin).
- if_to_id_valid = fs_valid & !br_taken. The instruction sitting in IF while ID redirects is the wrong-path slot and is squashed.
- IF fires to ID when if_to_id_valid & id_allowin.

Next PC (priority order):
1. br_taken → br_target.
2. br_pend → br_pend_target.
3. Otherwise fs_pc+4, mod 2^32 (wraps 0xfffffffc → 0).

Request and IF update:
- inst_sram_en = to_fs_valid & fs_allowin; addr = nextpc.
- When a request is issued, fs_pc<=nextpc and fs_valid<=1 on the next edge.
- If fs_allowin=0, fs_valid and fs_pc hold. If fs_valid=1 and ID fires while no new request is possible, fs_valid<=0.

Pending branch:
- If br_taken while fs_allowin=0, latch br_pend=1 and br_pend_target=br_target, and clear fs_valid (squash).
- br_pend clears on the next issued request.
- br_taken with fs_allowin=1 never sets br_pend.

Instruction buffer:
- rdata is valid only in the cycle after a request.
- If that cycle has fs_valid=1, !br_taken and !id_allowin, latch rdata into inst_buf and set buf_valid=1.
- if_to_id_inst = buf_valid ? inst_buf : inst_sram_rdata.
- buf_valid clears when IF fires to ID, on br_taken, or on reset.
- While buf_valid=1 and ID stalls, no new request is issued and rdata is ignored.

Simultaneous events:
- br_taken in the same cycle as an ID stall: the squash wins, buf_valid<=0, and the redirect uses the pending path.
- Reset asserted mid-fetch: all state is cleared immediately. Any in-flight rdata is ignored because fs_valid=0.

Alignment:
- Addresses are passed through unmodified. Misaligned-fetch exceptions are out of scope for this block.

Test Plan:
1. Reset release, id_allowin=1 → addr sequence 0x1c000000, 0x1c000004, 0x1c000008. if_to_id_pc follows one cycle behind with the matching rdata; if_to_id_valid=1 from the second post-reset cycle.
2. ID stall: id_allowin=0 for 3 cycles while IF holds pc 0x1c000008 with rdata 0x02800421 → inst_sram_en=0 during the stall, and if_to_id_inst stays 0x02800421 even though rdata changes to 0xdeadbeef. On release, next addr=0x1c00000c; no duplicate and no skipped PC.
3. Redirect: br_taken=1, br_target=0x1c000100 while IF holds 0x1c000010 → if_to_id_valid=0 that cycle and addr=0x1c000100. 0x1c000010 never reaches ID; next presented pc is 0x1c000100.
4. Redirect during a buffered stall: buf_valid=1 and br_taken with target 0x1c000200 → buffer is discarded. The first valid pc to ID after the stall clears is 0x1c000200.
5. Async reset asserted mid-stream at pc 0x1c000040 → if_to_id_valid and inst_sram_en drop to 0 without waiting for a clock edge. After release, fetch restarts at 0x1c000000.
6. Wrap-around: redirect to 0xfffffffc → next sequential addr=0x00000000.
